// File: rtl/wled_pkg.sv
// Shared state type, GRB field layout and level constants for the WS2812 chain sequencer.
package wled_pkg;

  typedef enum logic [1:0] {IDLE, SNAP, WRITE, GAP} state_t;

  localparam int G_OFS = 16;
  localparam int R_OFS = 8;
  localparam int B_OFS = 0;

  localparam int         LED_NUM_W  = 8;
  localparam logic [7:0] LEVEL_FULL = 8'hFF;

  // Each set colour flag becomes the on-level, each clear flag becomes zero.
  function automatic logic [23:0] make_grb(input logic g, input logic r, input logic b,
                                           input logic [7:0] level);
    logic [23:0] v;
    v = '0;
    v[G_OFS +: 8] = g ? level : 8'h00;
    v[R_OFS +: 8] = r ? level : 8'h00;
    v[B_OFS +: 8] = b ? level : 8'h00;
    return v;
  endfunction

endpackage

// File: rtl/wled_refresh_timer.sv
// Free-running divider that emits a one-cycle tick every CLK_MHZ*1000*REFRESH_MS clocks.
module wled_refresh_timer #(
  parameter int CLK_MHZ    = 27,
  parameter int REFRESH_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int PERIOD = CLK_MHZ * 1000 * REFRESH_MS;
  localparam int CNT_W  = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (count == LAST);
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wled_chain_ctrl.sv
// Snapshots per-LED colour flags and writes them one LED at a time into a ws2812 driver.
// Optional macro WLED_BRIGHTNESS_EN makes the on-level follow the brightness input.
module wled_chain_ctrl
  import wled_pkg::*;
#(
  parameter int CLK_MHZ    = 27,
  parameter int NUM_LEDS   = 8,
  parameter int REFRESH_MS = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_LEDS-1:0] led_green,
  input  logic [NUM_LEDS-1:0] led_red,
  input  logic [NUM_LEDS-1:0] led_blue,
  input  logic [7:0]          brightness,
  output logic [23:0]         rgb_data,
  output logic [7:0]          led_num,
  output logic                write,
  output logic                busy,
  output logic                frame_done
);

  localparam logic [LED_NUM_W-1:0] LAST_IDX = LED_NUM_W'(NUM_LEDS - 1);

  state_t               state;
  logic                 pending;
  logic                 tick;
  logic                 change;
  logic [LED_NUM_W-1:0] idx;
  logic [LED_NUM_W-1:0] nxt_idx;
  logic [NUM_LEDS-1:0]  snap_g, snap_r, snap_b;
  logic                 nxt_g, nxt_r, nxt_b;
  logic [7:0]           live_level, snap_level;

  wled_refresh_timer #(
    .CLK_MHZ    (CLK_MHZ),
    .REFRESH_MS (REFRESH_MS)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  wire flags_differ = (led_green != snap_g) || (led_red != snap_r) || (led_blue != snap_b);

`ifdef WLED_BRIGHTNESS_EN
  logic [7:0] snap_bri;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      snap_bri <= 8'h00;
    else if (state == SNAP)
      snap_bri <= brightness;
  end

  assign live_level = brightness;
  assign snap_level = snap_bri;
  assign change     = flags_differ || (brightness != snap_bri);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign live_level = LEVEL_FULL;
  assign snap_level = LEVEL_FULL;
  assign change     = flags_differ;
`endif

  assign nxt_idx = idx + LED_NUM_W'(1);

  // Mux selection by loop keeps the index width independent of NUM_LEDS.
  always_comb begin
    nxt_g = 1'b0;
    nxt_r = 1'b0;
    nxt_b = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (nxt_idx == LED_NUM_W'(i)) begin
        nxt_g = snap_g[i];
        nxt_r = snap_r[i];
        nxt_b = snap_b[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= 1'b1;
      idx        <= '0;
      snap_g     <= '0;
      snap_r     <= '0;
      snap_b     <= '0;
      rgb_data   <= '0;
      led_num    <= '0;
      write      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      write      <= 1'b0;
      frame_done <= 1'b0;
      pending    <= pending | change | tick;
      unique case (state)
        IDLE: begin
          if (pending) begin
            busy  <= 1'b1;
            state <= SNAP;
          end
        end
        SNAP: begin
          // A tick landing in this cycle must still schedule another sweep.
          pending  <= tick;
          snap_g   <= led_green;
          snap_r   <= led_red;
          snap_b   <= led_blue;
          idx      <= '0;
          led_num  <= '0;
          rgb_data <= make_grb(led_green[0], led_red[0], led_blue[0], live_level);
          write    <= 1'b1;
          state    <= WRITE;
        end
        WRITE: begin
          if (idx == LAST_IDX)
            frame_done <= 1'b1;
          state <= GAP;
        end
        GAP: begin
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx      <= nxt_idx;
            led_num  <= nxt_idx;
            rgb_data <= make_grb(nxt_g, nxt_r, nxt_b, snap_level);
            write    <= 1'b1;
            state    <= WRITE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wled_chain_ctrl.sv
// Directed self-checking bench for wled_chain_ctrl with a 4-LED chain and a 1000-cycle refresh.
module tb_wled_chain_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  led_green = '0;
  logic [3:0]  led_red = '0;
  logic [3:0]  led_blue = '0;
  logic [7:0]  brightness = 8'hFF;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        write;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int sweeps = 0;
  int dones = 0;
  int busy_cycles = 0;
  int rise_cyc [2] = '{0, 0};
  logic prev_busy;

  wled_chain_ctrl #(
    .CLK_MHZ    (1),
    .NUM_LEDS   (4),
    .REFRESH_MS (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .led_green  (led_green),
    .led_red    (led_red),
    .led_blue   (led_blue),
    .brightness (brightness),
    .rgb_data   (rgb_data),
    .led_num    (led_num),
    .write      (write),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Cycle count since reset release, aligned with the refresh divider.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] g, input logic [3:0] r, input logic [3:0] b,
                               input logic [7:0] bri);
    led_green  = g;
    led_red    = r;
    led_blue   = b;
    brightness = bri;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Entered at the negedge of the SNAP cycle; leaves at the negedge of the last GAP cycle.
  task automatic checkSweep(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                            input logic [23:0] e2, input logic [23:0] e3);
    logic [23:0] exp_rgb [4];
    exp_rgb = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      step(1);
      checkOutput($sformatf("%s led%0d write", tag, i), {31'd0, write}, 32'd1);
      checkOutput($sformatf("%s led%0d num", tag, i), {24'd0, led_num}, i);
      checkOutput($sformatf("%s led%0d rgb", tag, i), {8'd0, rgb_data}, {8'd0, exp_rgb[i]});
      checkOutput($sformatf("%s led%0d done_w", tag, i), {31'd0, frame_done}, 32'd0);
      step(1);
      checkOutput($sformatf("%s led%0d gap_write", tag, i), {31'd0, write}, 32'd0);
      checkOutput($sformatf("%s led%0d gap_num", tag, i), {24'd0, led_num}, i);
      checkOutput($sformatf("%s led%0d gap_rgb", tag, i), {8'd0, rgb_data}, {8'd0, exp_rgb[i]});
      checkOutput($sformatf("%s led%0d gap_done", tag, i), {31'd0, frame_done}, (i == 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("%s led%0d busy", tag, i), {31'd0, busy}, 32'd1);
    end
  endtask

  initial begin
    // Power-up reset: every output at zero.
    #2 rst_n = 1'b0;
    step(2);
    checkOutput("rst rgb", {8'd0, rgb_data}, 32'd0);
    checkOutput("rst num", {24'd0, led_num}, 32'd0);
    checkOutput("rst write", {31'd0, write}, 32'd0);
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst done", {31'd0, frame_done}, 32'd0);

    // Release with all flags clear: forced first sweep of zeros.
    rst_n = 1'b1;
    step(1);
    checkOutput("boot snap busy", {31'd0, busy}, 32'd1);
    checkOutput("boot snap write", {31'd0, write}, 32'd0);
    checkSweep("boot", 24'h0, 24'h0, 24'h0, 24'h0);
    step(1);
    checkOutput("boot idle busy", {31'd0, busy}, 32'd0);

    // Single red flag on LED 1: SNAP one cycle after the change, write one after that.
    applyStimulus(4'b0000, 4'b0010, 4'b0000, 8'hFF);
    step(1);
    checkOutput("red pend busy", {31'd0, busy}, 32'd0);
    step(1);
    checkOutput("red snap busy", {31'd0, busy}, 32'd1);
    checkOutput("red snap write", {31'd0, write}, 32'd0);
    checkSweep("red", 24'h0, 24'h00FF00, 24'h0, 24'h0);
    step(1);
    checkOutput("red idle busy", {31'd0, busy}, 32'd0);

    // Blue LED 3 toggles during a sweep: old frame finishes, new sweep follows.
    applyStimulus(4'b0001, 4'b0010, 4'b0000, 8'hFF);
    step(2);
    checkOutput("mid snap busy", {31'd0, busy}, 32'd1);
    fork
      begin
        step(4);
        led_blue = 4'b1000;
      end
    join_none
    checkSweep("mid old", 24'hFF0000, 24'h00FF00, 24'h0, 24'h0);
    step(1);
    checkOutput("mid between busy", {31'd0, busy}, 32'd0);
    step(1);
    checkOutput("mid resnap busy", {31'd0, busy}, 32'd1);
    checkSweep("mid new", 24'hFF0000, 24'h00FF00, 24'h0, 24'h0000FF);
    step(3);
    checkOutput("mid settle busy", {31'd0, busy}, 32'd0);

    // Static inputs: only the refresh ticks at 1000 and 2000 start sweeps.
    prev_busy = busy;
    for (int k = 0; k < 2500; k++) begin
      step(1);
      if (busy && !prev_busy) begin
        if (sweeps < 2) rise_cyc[sweeps] = cyc;
        sweeps++;
      end
      if (frame_done) dones++;
      prev_busy = busy;
    end
    checkOutput("refresh sweeps", sweeps, 2);
    checkOutput("refresh dones", dones, 2);
    checkOutput("refresh first", rise_cyc[0], 1002);
    checkOutput("refresh second", rise_cyc[1], 2002);

    // Reset asserted during the WRITE of LED 2 aborts the sweep.
    applyStimulus(4'b0001, 4'b0100, 4'b1000, 8'hFF);
    step(2);
    checkOutput("abort snap busy", {31'd0, busy}, 32'd1);
    step(5);
    checkOutput("abort w2 write", {31'd0, write}, 32'd1);
    checkOutput("abort w2 num", {24'd0, led_num}, 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("abort rgb", {8'd0, rgb_data}, 32'd0);
    checkOutput("abort num", {24'd0, led_num}, 32'd0);
    checkOutput("abort write", {31'd0, write}, 32'd0);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort done", {31'd0, frame_done}, 32'd0);
    step(2);
    checkOutput("abort hold done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    step(1);
    checkOutput("abort resnap busy", {31'd0, busy}, 32'd1);
    checkSweep("abort full", 24'hFF0000, 24'h0, 24'h00FF00, 24'h0000FF);
    step(1);
    checkOutput("abort idle busy", {31'd0, busy}, 32'd0);

`ifdef WLED_BRIGHTNESS_EN
    applyStimulus(4'b1111, 4'b1111, 4'b1111, 8'h40);
    step(2);
    checkOutput("bri40 snap busy", {31'd0, busy}, 32'd1);
    checkSweep("bri40", 24'h404040, 24'h404040, 24'h404040, 24'h404040);
    step(1);
    checkOutput("bri40 idle busy", {31'd0, busy}, 32'd0);
    applyStimulus(4'b1111, 4'b1111, 4'b1111, 8'h10);
    step(2);
    checkOutput("bri10 snap busy", {31'd0, busy}, 32'd1);
    checkSweep("bri10", 24'h101010, 24'h101010, 24'h101010, 24'h101010);
    step(1);
    checkOutput("bri10 idle busy", {31'd0, busy}, 32'd0);
`else
    // Without the brightness feature a brightness change starts no sweep.
    applyStimulus(4'b0001, 4'b0100, 4'b1000, 8'h40);
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (busy) busy_cycles++;
    end
    checkOutput("bri ignored", busy_cycles, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
